// File: rtl/oser16_pkg.sv
// Shared types and constants for the OSER16 word sequencer.
// Phase width fixes the PCLK divide at 8:1.
package oser16_pkg;

   localparam int DATA_W = 16;
   localparam int PH_W = 3;
   localparam logic [PH_W-1:0] PH_LAST = 3'd7;

   typedef enum logic [1:0] {
      HOLD,
      IDLE,
      STREAM
   } state_t;

endpackage

// File: rtl/oser16_word_fifo.sv
// Show-ahead synchronous word FIFO feeding the sequencer.
// Pointers wrap modulo DEPTH; count disambiguates full/empty.
module oser16_word_fifo
   import oser16_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     fclk_w,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push;
   logic              pop;

   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;

   always_ff @(posedge fclk_w) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge fclk_w) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/oser16_word_sequencer.sv
// Feeds queued 16-bit words to an OSER16, one per PCLK period,
// generating PCLK (fclk_w/8) and the post-reset RESET hold.
module oser16_word_sequencer
   import oser16_pkg::*;
#(
   parameter logic [DATA_W-1:0] IDLE_WORD  = 16'h0000,
   parameter int                FIFO_DEPTH = 4,
   parameter int                HOLD_CYC   = 16
) (
   input  logic              fclk_w,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              pclk_o,
   output logic [DATA_W-1:0] oser_d,
   output logic              oser_reset,
   output logic              underrun,
   output logic [15:0]       words_sent,
   output logic              busy
);

   localparam int HW = $clog2(HOLD_CYC);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

   state_t            state;
   logic [PH_W-1:0]   ph;
   logic [PH_W-1:0]   ph_nxt;
   logic [HW-1:0]     hold;
   logic [DATA_W-1:0] head;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;
   logic              bnd;
   logic              push;
   logic              pop;

   assign ph_nxt   = ph + 1'b1;
   assign bnd      = ph == PH_LAST;
   assign in_ready = !full && state != HOLD;
   assign push     = in_valid && in_ready;
   assign pop      = bnd && !empty && state != HOLD;
   assign busy     = state == STREAM;

   oser16_word_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .fclk_w  (fclk_w),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (in_data),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // pclk_o is loaded from the next phase so it equals ph[2]
   always_ff @(posedge fclk_w) begin
      if (!rst) begin
         ph         <= '0;
         pclk_o     <= 1'b0;
         oser_d     <= IDLE_WORD;
         oser_reset <= 1'b1;
         underrun   <= 1'b0;
         words_sent <= '0;
         hold       <= '0;
         state      <= HOLD;
      end else begin
         ph       <= ph_nxt;
         pclk_o   <= ph_nxt[PH_W-1];
         underrun <= 1'b0;
         unique case (state)
            HOLD: begin
               if (hold == HOLD_LAST) begin
                  oser_reset <= 1'b0;
                  state      <= IDLE;
               end else begin
                  hold <= hold + 1'b1;
               end
            end
            IDLE: begin
               if (pop) begin
                  oser_d     <= head;
                  words_sent <= words_sent + 1'b1;
                  state      <= STREAM;
               end
            end
            STREAM: begin
               if (pop) begin
                  oser_d     <= head;
                  words_sent <= words_sent + 1'b1;
               end else if (bnd) begin
                  oser_d   <= IDLE_WORD;
                  underrun <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= HOLD;
         endcase
      end
   end

   always_ff @(posedge fclk_w) begin
      if (rst) assert (count <= CW'(FIFO_DEPTH));
   end

endmodule
